// File: rtl/kyber_enc_loader.sv
// kyber_enc_loader: feeds host byte buffers to a kyber_pke_enc core and drains its ciphertext
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_start / o_busy, o_done, o_err   host control and status
//   o_src_sel, o_src_addr, o_src_re   source buffer read port (0 rand, 1 ek, 2 msg, 3 seed)
//   i_src_data                        read data, valid one cycle after o_src_re
//   o_core_*                          set / readin / full_in / data_type / din / in_index / readout to the core
//   i_core_*                          input_type / readin_ok / done / dout_1 / dout_2 / out_index from the core
//   o_c_we, o_c_addr, o_c_wdata       ciphertext word write port, data = {dout_2, dout_1}
module kyber_enc_loader #(
   parameter int K         = 3,
   parameter int OUT_PAIRS = 272
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [1:0]  o_src_sel,
   output logic [10:0] o_src_addr,
   output logic        o_src_re,
   input  logic [7:0]  i_src_data,
   output logic        o_core_set,
   output logic        o_core_readin,
   output logic        o_core_full_in,
   output logic [3:0]  o_core_data_type,
   output logic [7:0]  o_core_din,
   output logic [15:0] o_core_in_index,
   input  logic [3:0]  i_core_input_type,
   input  logic        i_core_readin_ok,
   input  logic        i_core_done,
   output logic        o_core_readout,
   input  logic [15:0] i_core_dout_1,
   input  logic [15:0] i_core_dout_2,
   input  logic [15:0] i_core_out_index,
   output logic        o_c_we,
   output logic [8:0]  o_c_addr,
   output logic [31:0] o_c_wdata
);
   localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_WAIT_REQ = 3'd2, S_LOAD = 3'd3,
                          S_WAIT_DONE = 3'd4, S_DRAIN = 3'd5, S_FIN = 3'd6, S_ERR = 3'd7;
   localparam logic [10:0] EK_LEN = 11'(384 * K);
   localparam logic [15:0] PAIRS  = 16'(OUT_PAIRS);

   logic [2:0]  r_state;
   logic [3:0]  r_served, r_type;
   logic [10:0] r_n, r_idx;
   logic        r_rd, r_hold_v;
   logic [7:0]  r_hold_data;
   logic [15:0] r_p;

   logic        w_load, w_readin, w_xfer, w_last, w_idx_ok;
   logic [10:0] w_len;
   logic [3:0]  w_bit;

   // r_rd marks the cycle src_data is on the bus; r_hold_v keeps a byte the core refused.
   // A new read is only issued with nothing in flight, giving one byte per two cycles.
   assign w_load   = r_state == S_LOAD;
   assign w_len    = (r_type == 4'd2) ? EK_LEN : 11'd32;
   assign w_readin = w_load && (r_rd || r_hold_v);
   assign w_xfer   = w_readin && i_core_readin_ok;
   assign w_last   = r_idx == w_len - 11'd1;
   assign w_bit    = 4'd1 << (r_type[1:0] - 2'd1);
   assign w_idx_ok = i_core_out_index < PAIRS;

   assign o_src_re         = w_load && !r_rd && !r_hold_v && (r_n < w_len);
   assign o_src_sel        = w_load ? r_type[1:0] - 2'd1 : 2'd0;
   assign o_src_addr       = w_load ? r_n : 11'd0;
   assign o_core_readin    = w_readin;
   assign o_core_full_in   = w_xfer && w_last;
   assign o_core_din       = w_readin ? (r_rd ? i_src_data : r_hold_data) : 8'd0;
   assign o_core_in_index  = w_readin ? {5'd0, r_idx} : 16'd0;
   assign o_core_data_type = r_type;
   assign o_core_set       = r_state == S_SET;
   assign o_core_readout   = r_state == S_DRAIN;
   assign o_busy           = r_state != S_IDLE && r_state != S_ERR;
   assign o_done           = r_state == S_FIN;
   assign o_err            = r_state == S_ERR;
   assign o_c_we           = o_core_readout && w_idx_ok;
   assign o_c_addr         = o_c_we ? i_core_out_index[8:0] : 9'd0;
   assign o_c_wdata        = o_c_we ? {i_core_dout_2, i_core_dout_1} : 32'd0;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_served    <= '0;
         r_type      <= '0;
         r_n         <= '0;
         r_idx       <= '0;
         r_rd        <= 1'b0;
         r_hold_v    <= 1'b0;
         r_hold_data <= '0;
         r_p         <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_served <= '0;
               r_n      <= '0;
               r_idx    <= '0;
               r_p      <= '0;
               r_state  <= S_SET;
            end
            S_SET: r_state <= S_WAIT_REQ;
            S_WAIT_REQ: begin
               if (r_served == 4'hF) r_state <= S_WAIT_DONE;
               else if (i_core_done) r_state <= S_ERR;
               else if (i_core_input_type != 4'd0) begin
                  if (i_core_input_type > 4'd4 || r_served[i_core_input_type[1:0] - 2'd1]) r_state <= S_ERR;
                  else begin
                     r_type   <= i_core_input_type;
                     r_n      <= '0;
                     r_rd     <= 1'b0;
                     r_hold_v <= 1'b0;
                     r_state  <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               r_rd <= o_src_re;
               if (o_src_re) begin
                  r_n   <= r_n + 11'd1;
                  r_idx <= r_n;
               end
               if (r_rd && !w_xfer) begin
                  r_hold_v    <= 1'b1;
                  r_hold_data <= i_src_data;
               end else if (w_xfer) r_hold_v <= 1'b0;
               if (w_xfer && w_last) begin
                  r_served <= r_served | w_bit;
                  r_state  <= S_WAIT_REQ;
               end
            end
            S_WAIT_DONE: if (i_core_done) begin
               r_p     <= '0;
               r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!w_idx_ok) r_state <= S_ERR;
               else begin
                  r_p <= r_p + 16'd1;
                  if (r_p == PAIRS - 16'd1) r_state <= S_FIN;
               end
            end
            S_FIN: r_state <= S_IDLE;
            default: ;
         endcase
      end
   end
endmodule
